// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, flag positions, entry layout.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   localparam int FLAG_W = 3;
   localparam int ZERO   = 2;
   localparam int CB     = 1;
   localparam int NEG    = 0;

   // Stored entry is {y[W-1:0], sel, flags}
   function automatic int entry_w(input int w);
      return w + 2 + FLAG_W;
   endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer handshake bundle for the ALU result FIFO.
interface alu_result_fifo_if #(
   parameter int W = 8
);

   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_sel;
   logic [W:0]   in_y;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_y;
   logic [1:0]   out_sel;
   logic         out_zero;
   logic         out_cb;
   logic         out_neg;

   modport master (
      output in_valid, in_sel, in_y, out_ready,
      input  in_ready, out_valid, out_y, out_sel,
      input  out_zero, out_cb, out_neg
   );

   modport slave (
      input  in_valid, in_sel, in_y, out_ready,
      output in_ready, out_valid, out_y, out_sel,
      output out_zero, out_cb, out_neg
   );

endinterface

// File: rtl/alu_flags.sv
// Status flags derived from an ALU result and its op select.
module alu_flags
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W:0]        y,
   input  logic [1:0]        sel,
   output logic [FLAG_W-1:0] flags
);

   always_comb begin
      flags       = '0;
      flags[ZERO] = ~|y[W-1:0];
      // Bit W only means carry/borrow for arithmetic ops
      flags[CB]   = y[W] & ~sel[1];
      flags[NEG]  = y[W-1];
   end

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead result FIFO behind the ALU with saturating drop counter.
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   alu_result_fifo_if.slave           bus,
   output logic [$clog2(DEPTH):0]     count,
   output logic [7:0]                 drop_cnt
);

   localparam int EW = entry_w(W);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = PW'(0) + (PW+1)'(DEPTH);

   logic [EW-1:0]     mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [FLAG_W-1:0] flags;
   logic [EW-1:0]     head;
   logic              full;
   logic              push;
   logic              pop;

   alu_flags #(.W(W)) u_flags (
      .y     (bus.in_y),
      .sel   (bus.in_sel),
      .flags (flags)
   );

   assign full = (count == FULL_CNT);
   assign push = bus.in_valid && !full;
   assign pop  = (count != '0) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {bus.in_y[W-1:0], bus.in_sel, flags};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (bus.in_valid && full && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign head          = mem[rd_ptr];
   assign bus.in_ready  = !full;
   assign bus.out_valid = (count != '0);
   assign bus.out_y     = head[EW-1 -: W];
   assign bus.out_sel   = head[FLAG_W +: 2];
   assign bus.out_zero  = head[ZERO];
   assign bus.out_cb    = head[CB];
   assign bus.out_neg   = head[NEG];

endmodule
